// File: rtl/priority_encoder_32x5.sv
// Sequential 32-to-5 priority encoder: request pulses accumulate in a pending
// register and the lowest pending index is offered through a VALID/READY handshake.
module priority_encoder_32x5 #(
    parameter int N = 32,
    parameter int W = 5
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] REQ,
    input  logic         READY,
    output logic [W-1:0] Y,
    output logic         VALID,
    output logic [N-1:0] PEND,
    output logic [W:0]   PEND_CNT,
    output logic         DUP
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    state_t       r_state;
    logic [W-1:0] r_y;
    logic         r_valid;
    logic [N-1:0] r_pend;
    logic [W:0]   r_pend_cnt;
    logic         r_dup;

    logic         w_accept;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_remain;
    logic [W-1:0] w_sel;
    logic         w_any;
    logic         w_dup_hit;
    logic [W:0]   w_cnt_nxt;

    // Index 0 wins, so scan from the top and let lower set bits overwrite.
    function automatic logic [W-1:0] f_lowest(input logic [N-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = i[W-1:0];
            end
        end
        return idx;
    endfunction

    function automatic logic [W:0] f_popcount(input logic [N-1:0] v);
        logic [W:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + {{W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    assign w_accept = r_valid && READY;

    always_comb begin
        w_clr = '0;
        if (w_accept) begin
            w_clr[r_y] = 1'b1;
        end
    end

    // Set wins over clear: a re-request of the accepted index stays pending.
    assign w_remain  = (r_pend & ~w_clr) | REQ;
    assign w_sel     = f_lowest(w_remain);
    assign w_any     = |w_remain;
    assign w_dup_hit = |(REQ & r_pend & ~w_clr);
    assign w_cnt_nxt = f_popcount(w_remain);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_y        <= '0;
            r_valid    <= 1'b0;
            r_pend     <= '0;
            r_pend_cnt <= '0;
            r_dup      <= 1'b0;
        end else begin
            r_pend     <= w_remain;
            r_pend_cnt <= w_cnt_nxt;
            if (w_dup_hit) begin
                r_dup <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_y     <= w_sel;
                        r_valid <= 1'b1;
                        r_state <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    // Without READY the presented index is frozen; no preemption.
                    if (READY) begin
                        if (w_any) begin
                            r_y <= w_sel;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign Y        = r_y;
    assign VALID    = r_valid;
    assign PEND     = r_pend;
    assign PEND_CNT = r_pend_cnt;
    assign DUP      = r_dup;

endmodule

// File: tb/tb_priority_encoder_32x5.sv
// Bench for priority_encoder_32x5: directed scenarios with fixed expectations plus
// randomized traffic compared against a set-based reference model.
module tb_priority_encoder_32x5;

    logic        CLK;
    logic        RST;
    logic [31:0] REQ;
    logic        READY;
    logic [4:0]  Y;
    logic        VALID;
    logic [31:0] PEND;
    logic [5:0]  PEND_CNT;
    logic        DUP;

    int n_checks = 0;
    int n_fail   = 0;

    priority_encoder_32x5 #(.N(32), .W(5)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .READY(READY),
        .Y(Y), .VALID(VALID), .PEND(PEND), .PEND_CNT(PEND_CNT), .DUP(DUP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: a set of pending line numbers and the currently offered one.
    bit        m_set [32];
    int        m_y;
    bit        m_valid;
    bit        m_dup;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += m_set[i];
        return c;
    endfunction

    function automatic int m_first();
        for (int i = 0; i < 32; i++) if (m_set[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] m_pend_word();
        logic [31:0] w = '0;
        for (int i = 0; i < 32; i++) w[i] = m_set[i];
        return w;
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) m_set[i] = 1'b0;
            m_y = 0; m_valid = 0; m_dup = 0;
        end else begin
            int taken;
            taken = (m_valid && READY) ? m_y : -1;
            for (int i = 0; i < 32; i++) begin
                if (REQ[i] && m_set[i] && i != taken) m_dup = 1;
            end
            if (taken >= 0) m_set[taken] = 0;
            for (int i = 0; i < 32; i++) if (REQ[i]) m_set[i] = 1;
            if (!m_valid || READY) begin
                if (m_first() >= 0) begin
                    m_y = m_first();
                    m_valid = 1;
                end else begin
                    m_valid = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1; REQ = '0; READY = 0;
        tick(); tick();
        RST = 0;
        n_checks++; if (VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", VALID); end
        n_checks++; if (PEND !== 32'h0) begin n_fail++; $display("FAIL reset_pend: got %08h expected 0", PEND); end
        n_checks++; if (Y !== 5'd0) begin n_fail++; $display("FAIL reset_y: got %0d expected 0", Y); end
        REQ = 32'h0000_0014; READY = 1;
        tick();
        n_checks++; if (VALID !== 1'b1 || Y !== 5'd2) begin n_fail++; $display("FAIL pre_reset_out: got valid=%0b y=%0d expected valid=1 y=2", VALID, Y); end
        n_checks++; if (PEND_CNT !== 6'd2) begin n_fail++; $display("FAIL pre_reset_cnt: got %0d expected 2", PEND_CNT); end
        REQ = '0; RST = 1;
        tick();
        RST = 0;
        n_checks++; if (PEND !== 32'h0 || VALID !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got pend=%08h valid=%0b expected 0/0", PEND, VALID); end
        n_checks++; if (PEND_CNT !== 6'd0 || DUP !== 1'b0) begin n_fail++; $display("FAIL mid_reset_cnt_dup: got cnt=%0d dup=%0b expected 0/0", PEND_CNT, DUP); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (VALID !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got valid=%0b expected 0", VALID); end
        end
    endtask

    task automatic test_single();
        REQ = 32'h0000_0400; READY = 1;
        tick();
        REQ = '0;
        n_checks++; if (VALID !== 1'b1 || Y !== 5'd10) begin n_fail++; $display("FAIL single_out: got valid=%0b y=%0d expected 1/10", VALID, Y); end
        n_checks++; if (PEND_CNT !== 6'd1) begin n_fail++; $display("FAIL single_cnt: got %0d expected 1", PEND_CNT); end
        tick();
        n_checks++; if (VALID !== 1'b0 || PEND !== 32'h0) begin n_fail++; $display("FAIL single_drain: got valid=%0b pend=%08h expected 0/0", VALID, PEND); end
        n_checks++; if (Y !== 5'd10) begin n_fail++; $display("FAIL single_y_hold: got %0d expected 10", Y); end
    endtask

    task automatic test_priority();
        int exp_y [3] = '{0, 5, 31};
        REQ = 32'h8000_0021; READY = 1;
        tick();
        REQ = '0;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (VALID !== 1'b1 || Y !== exp_y[k][4:0]) begin n_fail++; $display("FAIL prio_y%0d: got valid=%0b y=%0d expected 1/%0d", k, VALID, Y, exp_y[k]); end
            n_checks++; if (PEND_CNT !== 6'(3 - k)) begin n_fail++; $display("FAIL prio_cnt%0d: got %0d expected %0d", k, PEND_CNT, 3 - k); end
            tick();
        end
        n_checks++; if (VALID !== 1'b0 || PEND_CNT !== 6'd0) begin n_fail++; $display("FAIL prio_end: got valid=%0b cnt=%0d expected 0/0", VALID, PEND_CNT); end
    endtask

    task automatic test_backpressure();
        READY = 0; REQ = 32'h0000_0100;
        tick();
        n_checks++; if (VALID !== 1'b1 || Y !== 5'd8) begin n_fail++; $display("FAIL bp_first: got valid=%0b y=%0d expected 1/8", VALID, Y); end
        REQ = 32'h0000_0001;
        tick();
        REQ = '0;
        n_checks++; if (Y !== 5'd8 || PEND !== 32'h0000_0101) begin n_fail++; $display("FAIL bp_no_preempt: got y=%0d pend=%08h expected 8/00000101", Y, PEND); end
        tick();
        n_checks++; if (Y !== 5'd8 || VALID !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got y=%0d valid=%0b expected 8/1", Y, VALID); end
        READY = 1;
        tick();
        n_checks++; if (Y !== 5'd0 || VALID !== 1'b1) begin n_fail++; $display("FAIL bp_next: got y=%0d valid=%0b expected 0/1", Y, VALID); end
        tick();
        n_checks++; if (VALID !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got valid=%0b expected 0", VALID); end
    endtask

    task automatic test_collision();
        READY = 0; REQ = 32'h0000_0008;
        tick();
        n_checks++; if (Y !== 5'd3 || VALID !== 1'b1) begin n_fail++; $display("FAIL coll_present: got y=%0d valid=%0b expected 3/1", Y, VALID); end
        READY = 1;
        tick();
        REQ = '0;
        n_checks++; if (Y !== 5'd3 || VALID !== 1'b1 || PEND !== 32'h8) begin n_fail++; $display("FAIL coll_again: got y=%0d valid=%0b pend=%08h expected 3/1/00000008", Y, VALID, PEND); end
        n_checks++; if (DUP !== 1'b0) begin n_fail++; $display("FAIL coll_dup: got %0b expected 0", DUP); end
        tick();
        n_checks++; if (VALID !== 1'b0) begin n_fail++; $display("FAIL coll_drain: got valid=%0b expected 0", VALID); end
    endtask

    task automatic test_dup_full();
        READY = 0; REQ = 32'hFFFF_FFFF;
        tick();
        n_checks++; if (PEND_CNT !== 6'd32 || PEND !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL full_cnt: got cnt=%0d pend=%08h expected 32/ffffffff", PEND_CNT, PEND); end
        n_checks++; if (DUP !== 1'b0) begin n_fail++; $display("FAIL full_dup_early: got %0b expected 0", DUP); end
        REQ = 32'h0000_0002;
        tick();
        REQ = '0;
        n_checks++; if (DUP !== 1'b1) begin n_fail++; $display("FAIL dup_set: got %0b expected 1", DUP); end
        n_checks++; if (Y !== 5'd0 || VALID !== 1'b1) begin n_fail++; $display("FAIL full_y0: got y=%0d valid=%0b expected 0/1", Y, VALID); end
        READY = 1;
        for (int k = 1; k < 32; k++) begin
            tick();
            n_checks++; if (Y !== 5'(k) || VALID !== 1'b1) begin n_fail++; $display("FAIL full_step%0d: got y=%0d valid=%0b expected %0d/1", k, Y, VALID, k); end
        end
        tick();
        n_checks++; if (VALID !== 1'b0 || PEND_CNT !== 6'd0) begin n_fail++; $display("FAIL full_end: got valid=%0b cnt=%0d expected 0/0", VALID, PEND_CNT); end
        n_checks++; if (DUP !== 1'b1) begin n_fail++; $display("FAIL dup_sticky: got %0b expected 1", DUP); end
        RST = 1;
        tick();
        RST = 0;
        n_checks++; if (DUP !== 1'b0) begin n_fail++; $display("FAIL dup_reset: got %0b expected 0", DUP); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            RST   = ($urandom_range(0, 299) == 0);
            READY = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: REQ = '0;
                1: REQ = 32'h1 << $urandom_range(0, 31);
                2: REQ = $urandom & $urandom & $urandom;
                default: REQ = $urandom & $urandom;
            endcase
            tick();
            n_checks++; if (VALID !== m_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %0b expected %0b", k, VALID, m_valid); end
            n_checks++; if (Y !== 5'(m_y)) begin n_fail++; $display("FAIL rnd_y@%0d: got %0d expected %0d", k, Y, m_y); end
            n_checks++; if (PEND !== m_pend_word()) begin n_fail++; $display("FAIL rnd_pend@%0d: got %08h expected %08h", k, PEND, m_pend_word()); end
            n_checks++; if (PEND_CNT !== 6'(m_count())) begin n_fail++; $display("FAIL rnd_cnt@%0d: got %0d expected %0d", k, PEND_CNT, m_count()); end
            n_checks++; if (DUP !== m_dup) begin n_fail++; $display("FAIL rnd_dup@%0d: got %0b expected %0b", k, DUP, m_dup); end
        end
        RST = 0; REQ = '0; READY = 1;
        tick();
    endtask

    initial begin
        RST = 1; REQ = '0; READY = 0;
        test_reset();
        test_single();
        test_priority();
        test_backpressure();
        test_collision();
        test_dup_full();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
